// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
//   master : controller side (drives strobes, mux selects, debug state, pulses)
//   slave  : datapath side (drives op, zero, mem_ready)
// Signals:
//   op[6:0], zero, mem_ready                   datapath -> controller
//   mem_req, AdrSrc, MemRead, MemWrite,        controller -> datapath
//   IRWrite, PCWrite, RegWrite, ResultSrc,
//   ALUSrcA, ALUSrcB, ALUOp, ImmSrc, state,
//   mem_err, illegal
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       AdrSrc;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic [3:0] state;
    logic       mem_err;
    logic       illegal;

    modport master (
        input  op, zero, mem_ready,
        output mem_req, AdrSrc, MemRead, MemWrite, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, state, mem_err, illegal
    );

    modport slave (
        output op, zero, mem_ready,
        input  mem_req, AdrSrc, MemRead, MemWrite, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, state, mem_err, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM (lw, sw, R, I-ALU, beq-class, jal, jalr).
// Moore-decoded datapath controls, memory request/ready handshake with a
// wait-state watchdog, and illegal-opcode detection.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset (returns to FETCH)
//   bus      multicycle_ctrl_if.master control bundle
//   instret  retired-instruction count, present only with MC_INSTRET_EN
// Parameters:
//   WAIT_MAX  cycles a memory state may wait for mem_ready (1..255)
//   CNT_W     instret width
// Build option: define MC_INSTRET_EN to add the instret counter and port.
module multicycle_ctrl #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_ctrl_if.master   bus
`ifdef MC_INSTRET_EN
    ,
    output logic [CNT_W-1:0]    instret
`endif
);
    if (WAIT_MAX < 1 || WAIT_MAX > 255 || CNT_W < 1) begin : g_param_chk
        $error("multicycle_ctrl: WAIT_MAX must be 1..255 and CNT_W >= 1");
    end

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // Last wait-counter value before the watchdog fires: the WAIT_MAX-th
    // cycle of a memory state sees wait_cnt == WAIT_MAX-1.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMREAD = 4'd3,
        MEMWB    = 4'd4,  MEMWRITE = 4'd5, EXECR  = 4'd6,  EXECI   = 4'd7,
        ALUWB    = 4'd8,  BEQ     = 4'd9,  JAL    = 4'd10, JALRADR = 4'd11,
        JALRPC   = 4'd12
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt;
    logic       mem_state;
    logic       timeout;
    logic       bad_op;

    assign mem_state = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
    assign timeout   = mem_state && !bus.mem_ready && (wait_cnt == WAIT_LAST);
    assign bus.state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // Next state, controls and the DECODE legality flag.
    always_comb begin
        state_d       = state_q;
        bad_op        = 1'b0;
        bus.mem_req   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.PCWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.ALUOp     = 2'b00;
        case (state_q)
            FETCH: begin
                bus.mem_req   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = bus.mem_ready;
                bus.PCWrite   = bus.mem_ready;
                // On timeout we stay in FETCH and retry; the counter clears.
                if (bus.mem_ready) state_d = DECODE;
            end
            DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BR:        state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    OP_JALR:      state_d = JALRADR;
                    default: begin
                        state_d = FETCH;
                        bad_op  = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                state_d     = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                bus.mem_req = 1'b1;
                bus.AdrSrc  = 1'b1;
                bus.MemRead = 1'b1;
                if (bus.mem_ready) state_d = MEMWB;
                else if (timeout)  state_d = FETCH;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
                state_d       = FETCH;
            end
            MEMWRITE: begin
                bus.mem_req  = 1'b1;
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
                if (bus.mem_ready || timeout) state_d = FETCH;
            end
            EXECR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b10;
                state_d     = ALUWB;
            end
            EXECI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = 2'b10;
                state_d     = ALUWB;
            end
            ALUWB: begin
                bus.RegWrite = 1'b1;
                state_d      = FETCH;
            end
            BEQ: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b01;
                bus.PCWrite = bus.zero;
                state_d     = FETCH;
            end
            JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.PCWrite = 1'b1;
                state_d     = ALUWB;
            end
            JALRADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                state_d     = JALRPC;
            end
            JALRPC: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.PCWrite = 1'b1;
                state_d     = ALUWB;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BR:   bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end

    // Wait counter: cleared on every state change and on abort (FETCH abort
    // re-enters FETCH without a state change), counts cycles without ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                wait_cnt <= '0;
        else if (state_d != state_q || timeout) wait_cnt <= '0;
        else if (mem_state && !bus.mem_ready)   wait_cnt <= wait_cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_err <= 1'b0;
            bus.illegal <= 1'b0;
        end else begin
            bus.mem_err <= timeout;
            bus.illegal <= (state_q == DECODE) && bad_op;
        end
    end

`ifdef MC_INSTRET_EN
    logic retire;
    assign retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BEQ) ||
                    ((state_q == MEMWRITE) && bus.mem_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         instret <= '0;
        else if (retire) instret <= instret + 1'b1;
    end
`endif
endmodule
